// File: rtl/whack_pkg.sv
// Shared definitions for the mole-pad front end and the processor's MMIO view.
// Holds the pad count, the scanner FSM states and the default scan timing.
package whack_pkg;

  localparam int NUM_PADS             = 9;
  localparam int DEF_DISCHARGE_CYCLES = 500;
  localparam int DEF_TIMEOUT_CYCLES   = 2000;
  localparam int DEF_THRESHOLD        = 800;
  localparam int DEF_DEBOUNCE_SCANS   = 3;

  typedef enum logic [1:0] {
    ST_DISCHARGE,
    ST_CHARGE,
    ST_EVAL
  } scan_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pad_debounce.sv
// Per-pad debouncer: flips the touched bit after DEBOUNCE_SCANS disagreeing scans
// and keeps a sticky event bit for each 0->1 flip.
module pad_debounce #(
  parameter int DEBOUNCE_SCANS = whack_pkg::DEF_DEBOUNCE_SCANS
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  input  logic eval,
  input  logic clear,
  output logic touched,
  output logic touch_event
);

  localparam int AW = $clog2(DEBOUNCE_SCANS + 1);

  logic [AW-1:0] agree;
  logic [AW-1:0] agree_inc;
  logic          flip;

  assign agree_inc = agree + AW'(1);
  assign flip      = eval && (raw != touched) && (agree_inc == AW'(DEBOUNCE_SCANS));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      agree       <= '0;
      touched     <= 1'b0;
      touch_event <= 1'b0;
    end else begin
      if (eval) begin
        if (raw == touched)
          agree <= '0;
        else if (flip) begin
          agree   <= '0;
          touched <= ~touched;
        end else
          agree <= agree_inc;
      end
      // A rising flip outranks a clear landing in the same cycle.
      if (flip && !touched)
        touch_event <= 1'b1;
      else if (clear)
        touch_event <= 1'b0;
    end
  end

endmodule

// File: rtl/cap_touch_scanner.sv
// Capacitive pad scanner: discharge, timed charge with per-pad rise counters,
// then a one-cycle evaluation feeding the per-pad debouncers.
module cap_touch_scanner #(
  parameter int NUM_PADS         = whack_pkg::NUM_PADS,
  parameter int DISCHARGE_CYCLES = whack_pkg::DEF_DISCHARGE_CYCLES,
  parameter int TIMEOUT_CYCLES   = whack_pkg::DEF_TIMEOUT_CYCLES,
  parameter int THRESHOLD        = whack_pkg::DEF_THRESHOLD,
  parameter int DEBOUNCE_SCANS   = whack_pkg::DEF_DEBOUNCE_SCANS
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_PADS-1:0] capacitive_sensors_in,
  output logic                capacitive_sensors_out,
  input  logic                clear_events,
  output logic [NUM_PADS-1:0] touched,
  output logic [NUM_PADS-1:0] touch_events,
  output logic                scan_done
);

  import whack_pkg::*;

  localparam int CW = $clog2(max2(DISCHARGE_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam int KW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] DIS_LAST = CW'(DISCHARGE_CYCLES - 1);
  localparam logic [CW-1:0] CHG_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [KW-1:0] K_SAT    = KW'(TIMEOUT_CYCLES);

  logic [NUM_PADS-1:0] sens_s1, sens_s2;
  logic                clr_s1, clr_s2;
  scan_state_t         state;
  logic [CW-1:0]       cyc;
  logic                eval;
  logic [NUM_PADS-1:0] raw;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sens_s1 <= '0;
      sens_s2 <= '0;
      clr_s1  <= 1'b0;
      clr_s2  <= 1'b0;
    end else begin
      sens_s1 <= capacitive_sensors_in;
      sens_s2 <= sens_s1;
      clr_s1  <= clear_events;
      clr_s2  <= clr_s1;
    end
  end

  // Charge always runs the full timeout so every scan has the same period.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                  <= ST_DISCHARGE;
      cyc                    <= '0;
      capacitive_sensors_out <= 1'b0;
      scan_done              <= 1'b0;
    end else begin
      case (state)
        ST_DISCHARGE: begin
          if (cyc == DIS_LAST) begin
            state                  <= ST_CHARGE;
            cyc                    <= '0;
            capacitive_sensors_out <= 1'b1;
          end else
            cyc <= cyc + CW'(1);
        end
        ST_CHARGE: begin
          if (cyc == CHG_LAST) begin
            state                  <= ST_EVAL;
            cyc                    <= '0;
            capacitive_sensors_out <= 1'b0;
            scan_done              <= 1'b1;
          end else
            cyc <= cyc + CW'(1);
        end
        ST_EVAL: begin
          state     <= ST_DISCHARGE;
          scan_done <= 1'b0;
        end
        default: begin
          state                  <= ST_DISCHARGE;
          cyc                    <= '0;
          capacitive_sensors_out <= 1'b0;
          scan_done              <= 1'b0;
        end
      endcase
    end
  end

  assign eval = (state == ST_EVAL);

  for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
    logic [KW-1:0] count;
    logic          risen;

    // The count stops on the cycle the synchronized input is first seen high.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        count <= '0;
        risen <= 1'b0;
      end else if (state == ST_EVAL) begin
        count <= '0;
        risen <= 1'b0;
      end else if (state == ST_CHARGE && !risen) begin
        if (sens_s2[i])
          risen <= 1'b1;
        else if (count != K_SAT)
          count <= count + KW'(1);
      end
    end

    assign raw[i] = !risen || (int'(count) >= THRESHOLD);

    pad_debounce #(
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_db (
      .clock      (clock),
      .reset      (reset),
      .raw        (raw[i]),
      .eval       (eval),
      .clear      (clr_s2),
      .touched    (touched[i]),
      .touch_event(touch_events[i])
    );
  end

endmodule

// File: tb/tb_cap_touch_scanner.sv
// Randomized and directed bench for cap_touch_scanner with a scan-level model.
// Pads are modelled as rising a set number of cycles after the charge line.
module tb_cap_touch_scanner;

  localparam int NP  = 9;
  localparam int DC  = 4;
  localparam int TO  = 16;
  localparam int THR = 8;
  localparam int DB  = 2;
  localparam int PER = DC + TO + 1;
  localparam int NEVER = 99;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          clear_events = 1'b0;
  logic [NP-1:0] sens_in = '0;
  logic          sens_out;
  logic [NP-1:0] touched;
  logic [NP-1:0] touch_events;
  logic          scan_done;

  int n_checks = 0;
  int n_fail   = 0;

  int delay [NP];
  int age     = 0;
  int clr_age = -1;

  logic [NP-1:0] m_touched = '0;
  logic [NP-1:0] m_events  = '0;
  int            m_agree [NP];

  cap_touch_scanner #(
    .NUM_PADS        (NP),
    .DISCHARGE_CYCLES(DC),
    .TIMEOUT_CYCLES  (TO),
    .THRESHOLD       (THR),
    .DEBOUNCE_SCANS  (DB)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .capacitive_sensors_in (sens_in),
    .capacitive_sensors_out(sens_out),
    .clear_events          (clear_events),
    .touched               (touched),
    .touch_events          (touch_events),
    .scan_done             (scan_done)
  );

  always #5 clock = ~clock;

  // One cycle: sample on the falling edge, then drive pads from the charge line.
  task automatic step();
    @(negedge clock);
    clear_events = 1'b0;
    if (sens_out) age++;
    else age = 0;
    for (int i = 0; i < NP; i++)
      sens_in[i] = sens_out && (age >= delay[i] + 1);
    if (clr_age >= 0 && age == clr_age) clear_events = 1'b1;
  endtask

  task automatic set_delays(input int base, input int pad, input int d);
    for (int i = 0; i < NP; i++) delay[i] = base;
    if (pad >= 0) delay[pad] = d;
  endtask

  task automatic model_clear();
    m_touched = '0;
    m_events  = '0;
    for (int i = 0; i < NP; i++) m_agree[i] = 0;
  endtask

  // Scan-level outcome: a pad rising at charge cycle d measures d+2.
  task automatic model_eval(input bit clr);
    logic [NP-1:0] set_bits;
    set_bits = '0;
    for (int i = 0; i < NP; i++) begin
      int  c;
      bit  rises, r;
      c     = delay[i] + 2;
      rises = (c <= TO - 1);
      r     = !rises || (c >= THR);
      if (r != m_touched[i]) begin
        m_agree[i]++;
        if (m_agree[i] == DB) begin
          m_agree[i]   = 0;
          m_touched[i] = ~m_touched[i];
          if (m_touched[i]) set_bits[i] = 1'b1;
        end
      end else
        m_agree[i] = 0;
    end
    m_events = (clr ? '0 : m_events) | set_bits;
  endtask

  task automatic run_scan(input string tag);
    bit seen;
    bit clr;
    seen = 1'b0;
    clr  = (clr_age >= 0);
    for (int c = 0; c < 2 * PER && !seen; c++) begin
      step();
      if (scan_done) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s scan_done_timeout: got none expected pulse within %0d cycles", tag, 2 * PER);
      clr_age = -1;
      return;
    end
    model_eval(clr);
    clr_age = -1;
    step();
    n_checks++;
    if (touched !== m_touched) begin
      n_fail++;
      $display("FAIL %s touched: got %h expected %h", tag, touched, m_touched);
    end
    n_checks++;
    if (touch_events !== m_events) begin
      n_fail++;
      $display("FAIL %s touch_events: got %h expected %h", tag, touch_events, m_events);
    end
    n_checks++;
    if (scan_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s scan_done_width: got %b expected 0", tag, scan_done);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_checks++;
    if ({sens_out, scan_done, touched, touch_events} !== '0) begin
      n_fail++;
      $display("FAIL %s reset_outputs: got out=%b done=%b touched=%h events=%h expected all 0",
               tag, sens_out, scan_done, touched, touch_events);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    set_delays(NEVER, -1, 0);
    clr_age = -1;
    model_clear();
    repeat (4) step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_reset_outputs("reset_hold");
    set_delays(NEVER, -1, 0);
    model_clear();
    repeat (5) step();
    check_reset_outputs("reset_end");
    reset = 1'b1;
    // Two idle scans; pads never rise so all read touched after the 2nd EVAL.
    for (int s = 0; s < 2 * PER + 1; s++) begin
      int  ph;
      if (s > 0) step();
      ph = s % PER;
      n_checks++;
      if (sens_out !== (ph >= DC && ph < DC + TO)) begin
        n_fail++;
        $display("FAIL idle charge_line@%0d: got %b expected %b", s, sens_out, (ph >= DC && ph < DC + TO));
      end
      n_checks++;
      if (scan_done !== (ph == PER - 1)) begin
        n_fail++;
        $display("FAIL idle scan_done@%0d: got %b expected %b", s, scan_done, (ph == PER - 1));
      end
      if (s == PER) begin
        n_checks++;
        if (touched !== '0) begin
          n_fail++;
          $display("FAIL idle touched_scan1: got %h expected 000", touched);
        end
      end
    end
    n_checks++;
    if (touched !== 9'h1FF || touch_events !== 9'h1FF) begin
      n_fail++;
      $display("FAIL idle touched_scan2: got %h/%h expected 1ff/1ff", touched, touch_events);
    end
  endtask

  task automatic test_untouched();
    do_reset();
    set_delays(3, -1, 0);
    repeat (3) run_scan("untouched");
  endtask

  task automatic test_single_touch();
    do_reset();
    set_delays(3, 4, 10);
    run_scan("single1");
    run_scan("single2");
    n_checks++;
    if (touched !== 9'h010 || touch_events !== 9'h010) begin
      n_fail++;
      $display("FAIL single_touch pad4: got %h/%h expected 010/010", touched, touch_events);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int s = 0; s < 4; s++) begin
      set_delays(3, 4, (s % 2 == 0) ? 10 : 3);
      run_scan("glitch");
    end
    n_checks++;
    if (touched !== '0 || touch_events !== '0) begin
      n_fail++;
      $display("FAIL glitch stays_clear: got %h/%h expected 000/000", touched, touch_events);
    end
  endtask

  task automatic test_clear_collision();
    do_reset();
    set_delays(3, 4, 10);
    repeat (2) run_scan("coll_pad4");
    delay[2] = 10;
    run_scan("coll_pad2a");
    clr_age = 15;  // synchronized clear arrives on the EVAL cycle
    run_scan("coll_pad2b");
    n_checks++;
    if (touch_events !== 9'h004) begin
      n_fail++;
      $display("FAIL clear_collision events: got %h expected 004", touch_events);
    end
    clr_age = 6;
    run_scan("coll_midclear");
    n_checks++;
    if (touch_events !== '0 || touched !== 9'h014) begin
      n_fail++;
      $display("FAIL mid_clear: got %h/%h expected 014/000", touched, touch_events);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_delays(3, 4, 10);
    repeat (2) run_scan("mid_pre");
    for (int c = 0; c < 2 * PER && age != 9; c++) step();
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    model_clear();
    repeat (3) step();
    reset = 1'b1;
    for (int s = 0; s <= DC; s++) begin
      if (s > 0) step();
      n_checks++;
      if (sens_out !== (s == DC)) begin
        n_fail++;
        $display("FAIL mid_restart charge_line@%0d: got %b expected %b", s, sens_out, (s == DC));
      end
    end
    repeat (2) run_scan("mid_post");
  endtask

  task automatic test_random();
    bit phys [NP];
    do_reset();
    for (int i = 0; i < NP; i++) phys[i] = 1'b0;
    for (int s = 0; s < 40; s++) begin
      for (int i = 0; i < NP; i++) begin
        if ($urandom_range(0, 3) == 0) phys[i] = ~phys[i];
        delay[i] = phys[i] ? int'($urandom_range(6, 20)) : int'($urandom_range(0, 5));
      end
      if ($urandom_range(0, 4) == 0) clr_age = int'($urandom_range(1, 15));
      run_scan("random");
    end
  endtask

  initial begin
    for (int i = 0; i < NP; i++) delay[i] = NEVER;
    test_reset();
    test_untouched();
    test_single_touch();
    test_glitch();
    test_clear_collision();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
